// File: rtl/pcs_rx_decode_pkg.sv
// Shared 8b/10b code-group (_dec) and octet (_oct) definitions plus FSM state types
// for the PCS receive decoder.
package pcs_rx_decode_pkg;

    typedef logic [9:0] code_group_t;
    typedef logic [7:0] octet_t;

    typedef enum logic [1:0] {
        LOSS_OF_SYNC,
        ACQUIRE,
        SYNC_ACQUIRED
    } sync_state_t;

    typedef enum logic [2:0] {
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        RECEIVE,
        EPD_T,
        RX_ERR
    } rx_state_t;

    // Code-groups as abcdeifghj, bit 9 = a; rdn/rdp = column for negative/positive running disparity
    localparam code_group_t k28_5_rdn_dec = 10'h0FA;
    localparam code_group_t k28_5_rdp_dec = 10'h305;
    localparam code_group_t k27_7_rdn_dec = 10'h368;
    localparam code_group_t k27_7_rdp_dec = 10'h097;
    localparam code_group_t k29_7_rdn_dec = 10'h2E8;
    localparam code_group_t k29_7_rdp_dec = 10'h117;
    localparam code_group_t k23_7_rdn_dec = 10'h3A8;
    localparam code_group_t k23_7_rdp_dec = 10'h057;
    localparam code_group_t k30_7_rdn_dec = 10'h1E8;
    localparam code_group_t k30_7_rdp_dec = 10'h217;
    localparam code_group_t d00_0_rdn_dec = 10'h274;
    localparam code_group_t d00_0_rdp_dec = 10'h18B;
    localparam code_group_t d01_0_rdn_dec = 10'h1D4;
    localparam code_group_t d01_0_rdp_dec = 10'h22B;
    localparam code_group_t d02_0_rdn_dec = 10'h2D4;
    localparam code_group_t d02_0_rdp_dec = 10'h12B;
    localparam code_group_t d03_0_rdn_dec = 10'h31B;
    localparam code_group_t d03_0_rdp_dec = 10'h314;
    localparam code_group_t d02_2_rdn_dec = 10'h2D5;
    localparam code_group_t d02_2_rdp_dec = 10'h125;
    localparam code_group_t d16_2_rdn_dec = 10'h1B5;
    localparam code_group_t d16_2_rdp_dec = 10'h245;
    localparam code_group_t d26_4_rdn_dec = 10'h16D;
    localparam code_group_t d26_4_rdp_dec = 10'h162;
    localparam code_group_t d06_5_dec     = 10'h19A;
    localparam code_group_t d21_5_dec     = 10'h2AA;
    localparam code_group_t d05_6_dec     = 10'h296;

    localparam octet_t k28_5_oct    = 8'hBC;
    localparam octet_t k27_7_oct    = 8'hFB;
    localparam octet_t k29_7_oct    = 8'hFD;
    localparam octet_t k23_7_oct    = 8'hF7;
    localparam octet_t k30_7_oct    = 8'hFE;
    localparam octet_t d00_0_oct    = 8'h00;
    localparam octet_t d01_0_oct    = 8'h01;
    localparam octet_t d02_0_oct    = 8'h02;
    localparam octet_t d03_0_oct    = 8'h03;
    localparam octet_t d02_2_oct    = 8'h42;
    localparam octet_t d16_2_oct    = 8'h50;
    localparam octet_t d26_4_oct    = 8'h9A;
    localparam octet_t d06_5_oct    = 8'hA6;
    localparam octet_t d21_5_oct    = 8'hB5;
    localparam octet_t d05_6_oct    = 8'hC5;
    localparam octet_t preamble_oct = 8'h55;

endpackage

// File: rtl/pcs_rx_decode_if.sv
// Code-group input and GMII-side receive outputs of the PCS receive decoder.
interface pcs_rx_decode_if;
    import pcs_rx_decode_pkg::*;

    code_group_t rx_code_group;
    octet_t      RXD;
    logic        RX_DV;
    logic        RX_ER;
    logic        receiving;
    logic        sync_status;
    logic        rx_even;

    modport master (
        output rx_code_group,
        input  RXD, RX_DV, RX_ER, receiving, sync_status, rx_even
    );

    modport slave (
        input  rx_code_group,
        output RXD, RX_DV, RX_ER, receiving, sync_status, rx_even
    );

endinterface

// File: rtl/pcs_rx_decode_decode_8b10b.sv
// Combinational 8b/10b classifier: a group is valid only if it is in the table
// and belongs to the column selected by the current running disparity.
module decode_8b10b
    import pcs_rx_decode_pkg::*;
(
    input  code_group_t code_group,
    input  logic        rd_pos,
    output octet_t      octet,
    output logic        is_k,
    output logic        valid,
    output logic        disp_flip
);

    logic in_table;
    logic neg_col;
    logic both_cols;

    always_comb begin
        octet     = 8'h00;
        is_k      = 1'b0;
        in_table  = 1'b1;
        neg_col   = 1'b0;
        both_cols = 1'b0;
        case (code_group)
            k28_5_rdn_dec, k28_5_rdp_dec: begin octet = k28_5_oct; is_k = 1'b1; neg_col = (code_group == k28_5_rdn_dec); end
            k27_7_rdn_dec, k27_7_rdp_dec: begin octet = k27_7_oct; is_k = 1'b1; neg_col = (code_group == k27_7_rdn_dec); end
            k29_7_rdn_dec, k29_7_rdp_dec: begin octet = k29_7_oct; is_k = 1'b1; neg_col = (code_group == k29_7_rdn_dec); end
            k23_7_rdn_dec, k23_7_rdp_dec: begin octet = k23_7_oct; is_k = 1'b1; neg_col = (code_group == k23_7_rdn_dec); end
            k30_7_rdn_dec, k30_7_rdp_dec: begin octet = k30_7_oct; is_k = 1'b1; neg_col = (code_group == k30_7_rdn_dec); end
            d00_0_rdn_dec, d00_0_rdp_dec: begin octet = d00_0_oct; neg_col = (code_group == d00_0_rdn_dec); end
            d01_0_rdn_dec, d01_0_rdp_dec: begin octet = d01_0_oct; neg_col = (code_group == d01_0_rdn_dec); end
            d02_0_rdn_dec, d02_0_rdp_dec: begin octet = d02_0_oct; neg_col = (code_group == d02_0_rdn_dec); end
            d03_0_rdn_dec, d03_0_rdp_dec: begin octet = d03_0_oct; neg_col = (code_group == d03_0_rdn_dec); end
            d02_2_rdn_dec, d02_2_rdp_dec: begin octet = d02_2_oct; neg_col = (code_group == d02_2_rdn_dec); end
            d16_2_rdn_dec, d16_2_rdp_dec: begin octet = d16_2_oct; neg_col = (code_group == d16_2_rdn_dec); end
            d26_4_rdn_dec, d26_4_rdp_dec: begin octet = d26_4_oct; neg_col = (code_group == d26_4_rdn_dec); end
            d06_5_dec:                    begin octet = d06_5_oct; both_cols = 1'b1; end
            d21_5_dec:                    begin octet = d21_5_oct; both_cols = 1'b1; end
            d05_6_dec:                    begin octet = d05_6_oct; both_cols = 1'b1; end
            default:                      in_table = 1'b0;
        endcase
    end

    assign valid     = in_table && (both_cols || (rd_pos ? !neg_col : neg_col));
    // Unbalanced groups (6 or 4 ones) are exactly the ones that flip running disparity
    assign disp_flip = ($countones(code_group) != 5);

endmodule

// File: rtl/pcs_rx_decode.sv
// PCS receive decoder: code-group sync, running disparity and GMII receive framing.
// state         | meaning
// LOSS_OF_SYNC  | no alignment, waiting for any /K28.5/
// ACQUIRE       | counting even-aligned /K28.5/ toward SYNC_COMMAS
// SYNC_ACQUIRED | aligned; counting consecutive invalid groups
// WAIT_FOR_K    | waiting for an even-aligned /K28.5/
// RX_K          | got /K28.5/, expecting /D16.2/
// IDLE_D        | inside idle ordered sets, /S/ opens a frame
// RECEIVE       | frame data
// EPD_T         | got /T/, expecting /R/
// RX_ERR        | error propagation until next /K28.5/
module pcs_rx_decode
    import pcs_rx_decode_pkg::*;
#(
    parameter int SYNC_COMMAS  = 3,
    parameter int LOSS_INVALID = 4
)(
    input  logic                  GTX_CLK,
    input  logic                  mr_main_reset,
    pcs_rx_decode_if.slave        gmii
);

    localparam int AW = $clog2(SYNC_COMMAS + 1);
    localparam int IW = $clog2(LOSS_INVALID + 1);

    sync_state_t   sync_q, sync_next;
    rx_state_t     rx_q, rx_next;
    logic [AW-1:0] acq_cnt, acq_next, acq_inc;
    logic [IW-1:0] inv_cnt, inv_next, inv_inc;
    logic          rx_disparity, rd_next;
    logic          rx_even_q, rx_even_next;
    octet_t        rxd_q, rxd_next;
    logic          dv_q, dv_next, er_q, er_next, rcv_q, rcv_next;

    octet_t        dec_octet;
    logic          dec_is_k, dec_valid, dec_flip;
    logic          comma, even_slot, is_s, is_t, is_r, is_data, is_d162;
    logic          sync_drop, in_frame;

    decode_8b10b u_decode (
        .code_group (gmii.rx_code_group),
        .rd_pos     (rx_disparity),
        .octet      (dec_octet),
        .is_k       (dec_is_k),
        .valid      (dec_valid),
        .disp_flip  (dec_flip)
    );

    // Commas are recognised in either column so alignment and disparity can be regained
    assign comma     = (gmii.rx_code_group == k28_5_rdn_dec) || (gmii.rx_code_group == k28_5_rdp_dec);
    assign even_slot = !rx_even_q;
    assign is_s      = dec_valid && dec_is_k && (dec_octet == k27_7_oct);
    assign is_t      = dec_valid && dec_is_k && (dec_octet == k29_7_oct);
    assign is_r      = dec_valid && dec_is_k && (dec_octet == k23_7_oct);
    assign is_data   = dec_valid && !dec_is_k;
    assign is_d162   = is_data && (dec_octet == d16_2_oct);
    assign acq_inc   = acq_cnt + 1'b1;
    assign inv_inc   = inv_cnt + 1'b1;

    always_comb begin
        rx_even_next = comma ? 1'b1 : !rx_even_q;
        if (comma)
            rd_next = (gmii.rx_code_group == k28_5_rdn_dec);
        else if (dec_valid)
            rd_next = rx_disparity ^ dec_flip;
        else
            rd_next = rx_disparity;
    end

    always_comb begin
        sync_next = sync_q;
        acq_next  = acq_cnt;
        inv_next  = inv_cnt;
        case (sync_q)
            LOSS_OF_SYNC: begin
                if (comma) begin
                    sync_next = ACQUIRE;
                    acq_next  = AW'(1);
                end
            end
            ACQUIRE: begin
                if (comma && even_slot) begin
                    if (acq_inc == AW'(SYNC_COMMAS)) begin
                        sync_next = SYNC_ACQUIRED;
                        acq_next  = '0;
                        inv_next  = '0;
                    end else begin
                        acq_next  = acq_inc;
                    end
                end else if (comma || !dec_valid) begin
                    sync_next = LOSS_OF_SYNC;
                    acq_next  = '0;
                end
            end
            SYNC_ACQUIRED: begin
                if (!dec_valid) begin
                    if (inv_inc == IW'(LOSS_INVALID)) begin
                        sync_next = LOSS_OF_SYNC;
                        inv_next  = '0;
                        acq_next  = '0;
                    end else begin
                        inv_next  = inv_inc;
                    end
                end else begin
                    inv_next = '0;
                end
            end
            default: begin
                sync_next = LOSS_OF_SYNC;
                acq_next  = '0;
                inv_next  = '0;
            end
        endcase
    end

    assign sync_drop = (sync_q == SYNC_ACQUIRED) && (sync_next != SYNC_ACQUIRED);
    assign in_frame  = (rx_q == RECEIVE) || (rx_q == EPD_T) || (rx_q == RX_ERR);

    always_comb begin
        rx_next  = rx_q;
        rxd_next = 8'h00;
        dv_next  = 1'b0;
        er_next  = 1'b0;
        rcv_next = 1'b0;
        if (sync_q != SYNC_ACQUIRED) begin
            rx_next = WAIT_FOR_K;
        end else if (sync_drop) begin
            rx_next = WAIT_FOR_K;
            er_next = in_frame;
        end else begin
            case (rx_q)
                WAIT_FOR_K: if (comma && even_slot) rx_next = RX_K;
                RX_K:       rx_next = is_d162 ? IDLE_D : WAIT_FOR_K;
                IDLE_D: begin
                    if (comma) begin
                        rx_next = RX_K;
                    end else if (is_s) begin
                        rx_next  = RECEIVE;
                        rxd_next = preamble_oct;
                        dv_next  = 1'b1;
                        rcv_next = 1'b1;
                    end else begin
                        rx_next = WAIT_FOR_K;
                    end
                end
                RECEIVE: begin
                    rcv_next = 1'b1;
                    if (is_data) begin
                        rxd_next = dec_octet;
                        dv_next  = 1'b1;
                    end else if (is_t) begin
                        rx_next = EPD_T;
                    end else begin
                        rx_next = RX_ERR;
                        dv_next = 1'b1;
                        er_next = 1'b1;
                    end
                end
                EPD_T: begin
                    if (is_r) begin
                        rx_next = WAIT_FOR_K;
                    end else begin
                        rx_next  = RX_ERR;
                        dv_next  = 1'b1;
                        er_next  = 1'b1;
                        rcv_next = 1'b1;
                    end
                end
                RX_ERR: begin
                    if (comma) begin
                        rx_next = RX_K;
                    end else begin
                        dv_next  = 1'b1;
                        er_next  = 1'b1;
                        rcv_next = 1'b1;
                    end
                end
                default: rx_next = WAIT_FOR_K;
            endcase
        end
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            sync_q       <= LOSS_OF_SYNC;
            rx_q         <= WAIT_FOR_K;
            acq_cnt      <= '0;
            inv_cnt      <= '0;
            rx_disparity <= 1'b0;
            rx_even_q    <= 1'b0;
            rxd_q        <= 8'h00;
            dv_q         <= 1'b0;
            er_q         <= 1'b0;
            rcv_q        <= 1'b0;
        end else begin
            sync_q       <= sync_next;
            rx_q         <= rx_next;
            acq_cnt      <= acq_next;
            inv_cnt      <= inv_next;
            rx_disparity <= rd_next;
            rx_even_q    <= rx_even_next;
            rxd_q        <= rxd_next;
            dv_q         <= dv_next;
            er_q         <= er_next;
            rcv_q        <= rcv_next;
        end
    end

    assign gmii.RXD         = rxd_q;
    assign gmii.RX_DV       = dv_q;
    assign gmii.RX_ER       = er_q;
    assign gmii.receiving   = rcv_q;
    assign gmii.sync_status = (sync_q == SYNC_ACQUIRED);
    assign gmii.rx_even     = rx_even_q;

endmodule
